pc_next_irq_unit: RTL and testbench

Parametrised next-PC unit for the MIPS32 core.
- Computes the PC redirect for jumps, branches and exception return.
- Adds an internal interrupt controller: edge-latched pending lines, priority select, computed vector table, EPC register and an in-service state machine.
- Sits in the ID stage between the register-file forward muxes and the PC register; drives the PC mux and the branch/jump hazard logic.

---
 rtl/pc_next_irq_unit.sv | 203 ++++++++++++++++++++
 tb/tb_pc_next_irq_unit.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_next_irq_unit.sv
// Next-PC unit for the MIPS32 ID stage with an integrated vectored interrupt controller.
// Build with WTG_IRQ_NEST_EN defined for a NEST_DEPTH-deep EPC stack with priority preemption.
module pc_next_irq_unit #(
  parameter int unsigned NUM_IRQ    = 3,
  parameter logic [31:0] VEC_BASE   = 32'h3464,
  parameter logic [31:0] VEC_STRIDE = 32'h9c,
  parameter int unsigned NEST_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         op,
  input  logic               valid,
  input  logic               stall,
  input  logic [31:0]        off32,
  input  logic [25:0]        imm26,
  input  logic [31:0]        data_x,
  input  logic [31:0]        data_y,
  input  logic [31:0]        pc_4,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  output logic [31:0]        pc_new,
  output logic               branched,
  output logic               jumped,
  output logic               is_branch,
  output logic               irq_taken,
  output logic [2:0]         irq_id,
  output logic [31:0]        epc,
  output logic               in_isr
);

`ifdef WTG_IRQ_NEST_EN
  localparam int unsigned STACK_DEPTH = NEST_DEPTH;
`else
  localparam int unsigned STACK_DEPTH = 1;
`endif
  localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);

  localparam logic [3:0] OP_J32  = 4'd1;
  localparam logic [3:0] OP_J26  = 4'd2;
  localparam logic [3:0] OP_BEQ  = 4'd3;
  localparam logic [3:0] OP_BNE  = 4'd4;
  localparam logic [3:0] OP_BLEZ = 4'd5;
  localparam logic [3:0] OP_BGTZ = 4'd6;
  localparam logic [3:0] OP_BLTZ = 4'd7;
  localparam logic [3:0] OP_BGEZ = 4'd8;
  localparam logic [3:0] OP_RET  = 4'd9;

  typedef enum logic {ST_IDLE = 1'b0, ST_ISR = 1'b1} state_t;

  // Reject configurations the 3-bit irq_id or the EPC stack cannot represent.
  if (NUM_IRQ == 0 || NUM_IRQ > 8 || NEST_DEPTH == 0) begin : g_cfg_check
    $error("pc_next_irq_unit: NUM_IRQ must be 1..8 and NEST_DEPTH at least 1");
  end

  state_t             state_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] in_service_q;
  logic [31:0]        epc_stack_q [STACK_DEPTH];
  logic [2:0]         id_stack_q  [STACK_DEPTH];
  logic [SPW-1:0]     sp_q;
  logic [31:0]        epc_q;

  logic [31:0]        j_addr;
  logic [31:0]        b_addr;
  logic [31:0]        redirect;
  logic [31:0]        vec_addr;
  logic               op_seq;
  logic               br_taken;
  logic               cand_valid;
  logic [2:0]         cand_idx;
  logic               can_take;
  logic               do_ret;
  logic [2:0]         top_id;
  logic [31:0]        epc_below;
  logic [NUM_IRQ-1:0] take_mask;
  logic [NUM_IRQ-1:0] ret_mask;

  // Redirect target and flags from the op decode
  always_comb begin
    j_addr   = {pc_4[31:28], imm26, 2'b00};
    b_addr   = pc_4 + {off32[29:0], 2'b00};
    redirect = pc_4;
    op_seq   = 1'b0;
    br_taken = 1'b0;
    jumped   = 1'b0;
    case (op)
      OP_J32: begin
        jumped   = 1'b1;
        redirect = data_x;
      end
      OP_J26: begin
        jumped   = 1'b1;
        redirect = j_addr;
      end
      OP_BEQ:  br_taken = (data_x == data_y);
      OP_BNE:  br_taken = (data_x != data_y);
      OP_BLEZ: br_taken = ($signed(data_x) <= 32'sd0);
      OP_BGTZ: br_taken = ($signed(data_x) > 32'sd0);
      OP_BLTZ: br_taken = data_x[31];
      OP_BGEZ: br_taken = ~data_x[31];
      OP_RET:  redirect = epc_q;
      default: op_seq   = 1'b1;
    endcase
    if (br_taken) redirect = b_addr;
    is_branch = (op >= OP_BEQ) && (op <= OP_BGEZ);
    branched  = br_taken;
  end

  // Lowest-index enabled pending line wins
  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = 3'd0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (pending_q[i] && irq_mask[i]) begin
        cand_valid = 1'b1;
        cand_idx   = 3'(i);
      end
    end
  end

  // Top-of-stack line and the return address that becomes visible after a pop
  always_comb begin
    top_id    = 3'd0;
    epc_below = epc_q;
    for (int k = 0; k < int'(STACK_DEPTH); k++) begin
      if (int'(sp_q) == k + 1) top_id = id_stack_q[k];
      if (int'(sp_q) == k + 2) epc_below = epc_stack_q[k];
    end
  end

`ifdef WTG_IRQ_NEST_EN
  logic higher_busy;
  logic stack_full;

  // Preemption needs every in-service line to be strictly lower priority
  always_comb begin
    higher_busy = 1'b0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      if (in_service_q[i] && (3'(i) <= cand_idx)) higher_busy = 1'b1;
    end
  end

  assign stack_full = (int'(sp_q) == int'(STACK_DEPTH));
  assign can_take   = (state_q == ST_IDLE) || (!stack_full && !higher_busy);
`else
  assign can_take   = (state_q == ST_IDLE);
`endif

  assign irq_taken = valid && !stall && op_seq && cand_valid && can_take;
  assign irq_id    = irq_taken ? cand_idx : 3'd0;
  assign vec_addr  = VEC_BASE + 32'(cand_idx) * VEC_STRIDE;
  assign pc_new    = irq_taken ? vec_addr : redirect;
  assign do_ret    = valid && !stall && (op == OP_RET) && (state_q == ST_ISR);

  always_comb begin
    take_mask = '0;
    ret_mask  = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      take_mask[i] = irq_taken && (cand_idx == 3'(i));
      ret_mask[i]  = do_ret && (top_id == 3'(i));
    end
  end

  // Pending capture runs through stalls; everything else moves only on accept or return
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      irq_prev_q   <= '0;
      in_service_q <= '0;
      sp_q         <= '0;
      epc_q        <= 32'd0;
      for (int k = 0; k < int'(STACK_DEPTH); k++) begin
        epc_stack_q[k] <= 32'd0;
        id_stack_q[k]  <= 3'd0;
      end
    end else begin
      pending_q    <= (pending_q & ~take_mask) | (irq & ~irq_prev_q);
      irq_prev_q   <= irq;
      in_service_q <= (in_service_q | take_mask) & ~ret_mask;
      if (irq_taken) begin
        for (int k = 0; k < int'(STACK_DEPTH); k++) begin
          if (int'(sp_q) == k) begin
            epc_stack_q[k] <= pc_4;
            id_stack_q[k]  <= cand_idx;
          end
        end
        sp_q    <= sp_q + SPW'(1);
        epc_q   <= pc_4;
        state_q <= ST_ISR;
      end else if (do_ret) begin
        sp_q  <= sp_q - SPW'(1);
        epc_q <= epc_below;
        if (sp_q == SPW'(1)) state_q <= ST_IDLE;
      end
    end
  end

  assign epc    = epc_q;
  assign in_isr = (state_q == ST_ISR);

endmodule

// File: tb/tb_pc_next_irq_unit.sv
// Bench for pc_next_irq_unit: redirect vector table, directed interrupt sequences and
// randomized traffic checked against a queue-based model of the interrupt controller.
module tb_pc_next_irq_unit;
  localparam int unsigned NUM_IRQ    = 3;
  localparam logic [31:0] VEC_BASE   = 32'h3464;
  localparam logic [31:0] VEC_STRIDE = 32'h9c;
  localparam int unsigned NEST_DEPTH = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         op;
  logic               valid;
  logic               stall;
  logic [31:0]        off32;
  logic [25:0]        imm26;
  logic [31:0]        data_x;
  logic [31:0]        data_y;
  logic [31:0]        pc_4;
  logic [NUM_IRQ-1:0] irq;
  logic [NUM_IRQ-1:0] irq_mask;
  logic [31:0]        pc_new;
  logic               branched;
  logic               jumped;
  logic               is_branch;
  logic               irq_taken;
  logic [2:0]         irq_id;
  logic [31:0]        epc;
  logic               in_isr;

  pc_next_irq_unit #(
    .NUM_IRQ(NUM_IRQ), .VEC_BASE(VEC_BASE), .VEC_STRIDE(VEC_STRIDE), .NEST_DEPTH(NEST_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .op(op), .valid(valid), .stall(stall), .off32(off32),
    .imm26(imm26), .data_x(data_x), .data_y(data_y), .pc_4(pc_4), .irq(irq),
    .irq_mask(irq_mask), .pc_new(pc_new), .branched(branched), .jumped(jumped),
    .is_branch(is_branch), .irq_taken(irq_taken), .irq_id(irq_id), .epc(epc), .in_isr(in_isr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending bits per line, return stack as queues
  bit          m_pend [NUM_IRQ];
  bit          m_prev [NUM_IRQ];
  logic [31:0] m_epc;
  logic [31:0] stk_pc [$];
  int          stk_id [$];

  logic [31:0] obs_pc;
  logic        obs_br, obs_j, obs_isb, obs_taken;
  logic [2:0]  obs_id;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] off;
    logic [31:0] pc4;
    logic [25:0] imm;
    logic [31:0] exp_pc;
    logic        exp_br;
    logic        exp_j;
    logic        exp_isb;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_cand();
    for (int i = 0; i < int'(NUM_IRQ); i++)
      if (m_pend[i] && irq_mask[i]) return i;
    return -1;
  endfunction

  function automatic bit model_accept(input int cand);
    if (!valid || stall || cand < 0) return 1'b0;
    if (!(op == 4'd0 || op >= 4'd10)) return 1'b0;
    if (stk_pc.size() == 0) return 1'b1;
`ifdef WTG_IRQ_NEST_EN
    if (stk_pc.size() >= int'(NEST_DEPTH)) return 1'b0;
    foreach (stk_id[k]) if (stk_id[k] <= cand) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_redirect(output logic [31:0] pc, output logic br, output logic j,
                                output logic isb);
    logic signed [31:0] x;
    x   = data_x;
    br  = 1'b0;
    j   = 1'b0;
    isb = (op >= 4'd3) && (op <= 4'd8);
    pc  = pc_4;
    case (op)
      4'd1: begin pc = data_x; j = 1'b1; end
      4'd2: begin pc = {pc_4[31:28], imm26, 2'b00}; j = 1'b1; end
      4'd3: br = (data_x == data_y);
      4'd4: br = (data_x != data_y);
      4'd5: br = (x <= 0);
      4'd6: br = (x > 0);
      4'd7: br = (x < 0);
      4'd8: br = (x >= 0);
      4'd9: pc = m_epc;
      default: ;
    endcase
    if (br) pc = pc_4 + (off32 << 2);
  endtask

  // One clock: check combinational outputs before the edge, advance model, check state after
  task automatic run_cycle();
    logic [31:0] e_pc;
    logic        e_br, e_j, e_isb, e_take;
    int          cand;
    #1;
    cand   = model_cand();
    e_take = model_accept(cand);
    model_redirect(e_pc, e_br, e_j, e_isb);
    if (e_take) e_pc = VEC_BASE + 32'(cand) * VEC_STRIDE;
    obs_pc = pc_new; obs_br = branched; obs_j = jumped; obs_isb = is_branch;
    obs_taken = irq_taken; obs_id = irq_id;
    chk("model pc_new", obs_pc, e_pc);
    chk("model branched", obs_br, e_br);
    chk("model jumped", obs_j, e_j);
    chk("model is_branch", obs_isb, e_isb);
    chk("model irq_taken", obs_taken, e_take);
    if (e_take) chk("model irq_id", obs_id, 32'(cand));
    @(posedge clk);
    if (rst) begin
      foreach (m_pend[i]) begin m_pend[i] = 1'b0; m_prev[i] = 1'b0; end
      stk_pc.delete();
      stk_id.delete();
      m_epc = 32'd0;
    end else begin
      foreach (m_pend[i]) begin
        m_pend[i] = (m_pend[i] && !(e_take && cand == i)) || (irq[i] && !m_prev[i]);
        m_prev[i] = irq[i];
      end
      if (e_take) begin
        stk_pc.push_back(pc_4);
        stk_id.push_back(cand);
        m_epc = pc_4;
      end else if (valid && !stall && op == 4'd9 && stk_pc.size() > 0) begin
        void'(stk_pc.pop_back());
        void'(stk_id.pop_back());
        if (stk_pc.size() > 0) m_epc = stk_pc[$];
      end
    end
    #1;
    chk("model epc", epc, m_epc);
    chk("model in_isr", in_isr, 32'(stk_pc.size() > 0));
  endtask

  task automatic set_seq(input logic [31:0] pc);
    rst = 1'b0; op = 4'd0; valid = 1'b1; stall = 1'b0; pc_4 = pc;
  endtask

  task automatic set_op(input logic [3:0] o, input logic [31:0] pc);
    rst = 1'b0; op = o; valid = 1'b1; stall = 1'b0; pc_4 = pc;
  endtask

  initial begin
    rst = 1'b1; op = 4'd0; valid = 1'b0; stall = 1'b0; off32 = 32'd0; imm26 = 26'd0;
    data_x = 32'd0; data_y = 32'd0; pc_4 = 32'd0; irq = '0; irq_mask = '0;
    foreach (m_pend[i]) begin m_pend[i] = 1'b0; m_prev[i] = 1'b0; end
    m_epc = 32'd0;

    tbl[0]  = '{4'd3, 32'd5, 32'd5, 32'hFFFF_FFFE, 32'h3000, 26'd0, 32'h2FF8, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{4'd3, 32'd5, 32'd6, 32'hFFFF_FFFE, 32'h3000, 26'd0, 32'h3000, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{4'd4, 32'd5, 32'd6, 32'd4, 32'h3000, 26'd0, 32'h3010, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{4'd5, 32'd0, 32'd0, 32'd1, 32'h3000, 26'd0, 32'h3004, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{4'd5, 32'd1, 32'd0, 32'd1, 32'h3000, 26'd0, 32'h3000, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{4'd6, 32'h8000_0000, 32'd0, 32'd1, 32'h3000, 26'd0, 32'h3000, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{4'd6, 32'd7, 32'd0, 32'd2, 32'h3000, 26'd0, 32'h3008, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{4'd7, 32'hFFFF_FFFF, 32'd0, 32'h10, 32'h3000, 26'd0, 32'h3040, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{4'd8, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h3000, 26'd0, 32'h3000, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{4'd8, 32'd0, 32'd0, 32'd3, 32'h3000, 26'd0, 32'h300C, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{4'd1, 32'hDEAD_BEE0, 32'd0, 32'd0, 32'h3000, 26'd0, 32'hDEAD_BEE0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{4'd2, 32'd0, 32'd0, 32'd0, 32'hA000_0010, 26'h3FF_FFFF, 32'hAFFF_FFFC, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{4'd0, 32'd0, 32'd0, 32'd0, 32'h1234_5678, 26'd0, 32'h1234_5678, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{4'd12, 32'd0, 32'd0, 32'd0, 32'h1234_5678, 26'd0, 32'h1234_5678, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{4'd9, 32'd0, 32'd0, 32'd0, 32'h3000, 26'd0, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{4'd8, 32'd0, 32'd0, 32'd1, 32'hFFFF_FFFC, 26'd0, 32'h0, 1'b1, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; valid = 1'b1;
    #1;
    chk("reset epc", epc, 32'd0);
    chk("reset in_isr", in_isr, 32'd0);
    chk("reset irq_taken", irq_taken, 32'd0);

    // Redirect table, no interrupts enabled; the RET entry sees the post-reset epc
    foreach (tbl[i]) begin
      set_op(tbl[i].op, tbl[i].pc4);
      data_x = tbl[i].x; data_y = tbl[i].y; off32 = tbl[i].off; imm26 = tbl[i].imm;
      run_cycle();
      chk($sformatf("tbl%0d pc_new", i), obs_pc, tbl[i].exp_pc);
      chk($sformatf("tbl%0d branched", i), obs_br, tbl[i].exp_br);
      chk($sformatf("tbl%0d jumped", i), obs_j, tbl[i].exp_j);
      chk($sformatf("tbl%0d is_branch", i), obs_isb, tbl[i].exp_isb);
    end
    chk("ret idle in_isr", in_isr, 32'd0);

    // Line 1 accepted, then RET back to the interrupted address
    irq_mask = 3'b111; irq = 3'b010; set_seq(32'h1234);
    run_cycle();
    run_cycle();
    chk("l1 taken", obs_taken, 32'd1);
    chk("l1 id", obs_id, 32'd1);
    chk("l1 vector", obs_pc, 32'h3500);
    chk("l1 epc", epc, 32'h1234);
    chk("l1 in_isr", in_isr, 32'd1);
    set_op(4'd9, 32'h2000);
    run_cycle();
    chk("l1 ret pc", obs_pc, 32'h1234);
    chk("l1 ret in_isr", in_isr, 32'd0);
    set_seq(32'h2000);
    run_cycle();
    chk("l1 pending cleared", obs_taken, 32'd0);
    irq = 3'b000;
    run_cycle();

    // Lines 0 and 2 together; J26 blocks, then line 0 wins and line 2 stays pending
    irq = 3'b101; set_seq(32'h4000);
    run_cycle();
    set_op(4'd2, 32'h4004); imm26 = 26'd0;
    run_cycle();
    chk("j26 no accept", obs_taken, 32'd0);
    chk("j26 pc", obs_pc, 32'h0);
    set_seq(32'h4008);
    run_cycle();
    chk("l0 taken", obs_taken, 32'd1);
    chk("l0 id", obs_id, 32'd0);
    chk("l0 vector", obs_pc, 32'h3464);
    set_op(4'd9, 32'h4100);
    run_cycle();
    chk("l0 ret pc", obs_pc, 32'h4008);
    set_seq(32'h5000);
    run_cycle();
    chk("l2 kept pending", obs_taken, 32'd1);
    chk("l2 id", obs_id, 32'd2);
    chk("l2 vector", obs_pc, 32'h359c);
    set_op(4'd9, 32'h5004);
    run_cycle();
    irq = 3'b000;
    run_cycle();

    // Masked line latches but waits for its enable
    irq_mask = 3'b011; irq = 3'b100; set_seq(32'h6000);
    run_cycle();
    run_cycle();
    chk("masked no accept a", obs_taken, 32'd0);
    run_cycle();
    chk("masked no accept b", obs_taken, 32'd0);
    irq_mask = 3'b111;
    run_cycle();
    chk("unmasked accept", obs_taken, 32'd1);
    chk("unmasked vector", obs_pc, 32'h359c);
    set_op(4'd9, 32'h6004);
    run_cycle();
    irq = 3'b000;
    run_cycle();

    // Stall defers acceptance and holds a RET
    irq = 3'b010; set_seq(32'h6100); stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      chk("stall no accept", obs_taken, 32'd0);
      chk("stall in_isr", in_isr, 32'd0);
    end
    stall = 1'b0;
    run_cycle();
    chk("stall released accept", obs_taken, 32'd1);
    chk("stall released vector", obs_pc, 32'h3500);
    set_op(4'd9, 32'h6200); stall = 1'b1;
    run_cycle();
    chk("stalled ret holds", in_isr, 32'd1);
    stall = 1'b0;
    run_cycle();
    chk("ret after stall", in_isr, 32'd0);
    irq = 3'b000;
    run_cycle();

    // Line 0 arrives while line 2 is in service
    irq = 3'b100; set_seq(32'h7000);
    run_cycle();
    run_cycle();
    chk("outer taken", obs_taken, 32'd1);
    irq = 3'b101; set_seq(32'h7100);
    run_cycle();
    set_seq(32'h7104);
    run_cycle();
`ifdef WTG_IRQ_NEST_EN
    chk("preempt taken", obs_taken, 32'd1);
    chk("preempt vector", obs_pc, 32'h3464);
    chk("preempt epc", epc, 32'h7104);
    set_op(4'd9, 32'h7200);
    run_cycle();
    chk("inner ret pc", obs_pc, 32'h7104);
    chk("inner ret in_isr", in_isr, 32'd1);
    chk("inner ret epc", epc, 32'h7000);
    run_cycle();
    chk("outer ret pc", obs_pc, 32'h7000);
    chk("outer ret in_isr", in_isr, 32'd0);
`else
    chk("no preempt", obs_taken, 32'd0);
    set_op(4'd9, 32'h7200);
    run_cycle();
    chk("outer ret pc", obs_pc, 32'h7000);
    chk("outer ret in_isr", in_isr, 32'd0);
    set_seq(32'h7300);
    run_cycle();
    chk("deferred l0 taken", obs_taken, 32'd1);
    chk("deferred l0 id", obs_id, 32'd0);
    set_op(4'd9, 32'h7400);
    run_cycle();
    chk("deferred l0 ret pc", obs_pc, 32'h7300);
`endif
    irq = 3'b000;
    run_cycle();

    // Reset in the middle of a handler
    irq = 3'b010; set_seq(32'h8000);
    run_cycle();
    run_cycle();
    chk("pre-reset in_isr", in_isr, 32'd1);
    rst = 1'b1;
    run_cycle();
    chk("mid-isr reset in_isr", in_isr, 32'd0);
    chk("mid-isr reset epc", epc, 32'd0);
    set_op(4'd9, 32'h8100);
    run_cycle();
    chk("ret after reset pc", obs_pc, 32'd0);
    chk("ret after reset in_isr", in_isr, 32'd0);
    irq = 3'b000;
    run_cycle();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int r;
      rst = ($urandom_range(0, 399) == 0);
      r = int'($urandom_range(0, 9));
      if (r < 5) op = 4'd0;
      else if (r == 5) op = 4'd9;
      else op = 4'($urandom_range(0, 15));
      valid  = ($urandom_range(0, 9) != 0);
      stall  = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < int'(NUM_IRQ); i++)
        if ($urandom_range(0, 5) == 0) irq[i] = ~irq[i];
      if ($urandom_range(0, 19) == 0) irq_mask = NUM_IRQ'($urandom_range(0, 7));
      data_x = $urandom;
      data_y = ($urandom_range(0, 2) == 0) ? data_x : $urandom;
      if ($urandom_range(0, 3) == 0) data_x = 32'd0;
      off32  = 32'(int'($urandom_range(0, 255)) - 128);
      imm26  = 26'($urandom);
      pc_4   = $urandom & 32'hFFFF_FFFC;
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
